regfile_writeback_queue: RTL and testbench

- Writer-side companion to the 32x32 register file.
- Buffers register writebacks (from EX/MEM/WB producers) in a small FIFO and drains them, in order, onto the register file's single write port whenever that port is granted.
- Provides a forwarding lookup so readers still get the newest value of any register that has a write pending but not yet retired.
- Sits between the pipeline writeback stage and the register file's regwrite/writeaddr/writedata inputs.

---
 rtl/regfile_writeback_queue.sv | 140 ++++++++++++++
 tb/tb_regfile_writeback_queue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue in front of the register file's single write port.
// Also forwards the newest still-pending value of any register to readers.
module regfile_writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    wb_valid_i,
   output logic                    wb_ready_o,
   input  logic [ADDR_W-1:0]       wb_addr_i,
   input  logic [DATA_W-1:0]       wb_data_i,
   input  logic                    wr_grant_i,
   output logic                    regwrite_o,
   output logic [ADDR_W-1:0]       writeaddr_o,
   output logic [DATA_W-1:0]       writedata_o,
   input  logic [ADDR_W-1:0]       rsaddr_i,
   input  logic [ADDR_W-1:0]       rtaddr_i,
   output logic                    rs_hit_o,
   output logic [DATA_W-1:0]       rs_data_o,
   output logic                    rt_hit_o,
   output logic [DATA_W-1:0]       rt_data_o,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  head_reg, head_next;
   logic [PTR_W-1:0]  tail_reg, tail_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [DEPTH-1:0]  valid_reg;
   logic [ADDR_W-1:0] addr_reg [DEPTH];
   logic [DATA_W-1:0] data_reg [DEPTH];

   logic not_empty;
   logic push;
   logic pop;

   // Ready comes from registered occupancy only, so a pop never opens a slot in the same cycle.
   assign not_empty  = (count_reg != '0);
   assign wb_ready_o = (count_reg < CNT_W'(DEPTH));
   assign push       = wb_valid_i & wb_ready_o & (wb_addr_i != '0);
   assign pop        = not_empty & wr_grant_i;

   assign regwrite_o  = pop;
   assign writeaddr_o = not_empty ? addr_reg[head_reg] : '0;
   assign writedata_o = not_empty ? data_reg[head_reg] : '0;
   assign count_o     = count_reg;

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (pop) begin
         head_next = head_reg + PTR_W'(1);
      end
      if (push) begin
         tail_next = tail_reg + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   // Push and pop never target the same slot: push needs a free slot, pop needs an occupied one.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         valid_reg <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_reg[i] <= '0;
            data_reg[i] <= '0;
         end
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
         if (pop) begin
            valid_reg[head_reg] <= 1'b0;
         end
         if (push) begin
            valid_reg[tail_reg] <= 1'b1;
            addr_reg[tail_reg]  <= wb_addr_i;
            data_reg[tail_reg]  <= wb_data_i;
         end
      end
   end

   // Entries viewed oldest-first starting at head; higher index is younger.
   logic [PTR_W-1:0]  age_slot  [DEPTH];
   logic [DEPTH-1:0]  age_valid;
   logic [ADDR_W-1:0] age_addr  [DEPTH];
   logic [DATA_W-1:0] age_data  [DEPTH];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_slot[gi]  = head_reg + PTR_W'(gi);
      assign age_valid[gi] = valid_reg[age_slot[gi]];
      assign age_addr[gi]  = addr_reg[age_slot[gi]];
      assign age_data[gi]  = data_reg[age_slot[gi]];
   end

   // Port 0 serves rs, port 1 serves rt; the last match in age order is the youngest.
   for (genvar gp = 0; gp < 2; gp++) begin : g_look
      logic [ADDR_W-1:0] look_addr;
      logic [DEPTH-1:0]  match;
      logic              hit;
      logic [DATA_W-1:0] data;

      assign look_addr = (gp == 0) ? rsaddr_i : rtaddr_i;

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
         assign match[gi] = age_valid[gi] & (age_addr[gi] == look_addr);
      end

      always_comb begin
         hit  = 1'b0;
         data = '0;
         if (look_addr != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
               if (match[k]) begin
                  hit  = 1'b1;
                  data = age_data[k];
               end
            end
         end
      end
   end

   assign rs_hit_o  = g_look[0].hit;
   assign rs_data_o = g_look[0].data;
   assign rt_hit_o  = g_look[1].hit;
   assign rt_data_o = g_look[1].data;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: a queue-based reference model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_regfile_writeback_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst_i = 1'b1;
   logic              wb_valid_i = 1'b0;
   logic              wb_ready_o;
   logic [ADDR_W-1:0] wb_addr_i = '0;
   logic [DATA_W-1:0] wb_data_i = '0;
   logic              wr_grant_i = 1'b0;
   logic              regwrite_o;
   logic [ADDR_W-1:0] writeaddr_o;
   logic [DATA_W-1:0] writedata_o;
   logic [ADDR_W-1:0] rsaddr_i = '0;
   logic [ADDR_W-1:0] rtaddr_i = '0;
   logic              rs_hit_o;
   logic [DATA_W-1:0] rs_data_o;
   logic              rt_hit_o;
   logic [DATA_W-1:0] rt_data_o;
   logic [2:0]        count_o;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
      .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .wr_grant_i(wr_grant_i), .regwrite_o(regwrite_o),
      .writeaddr_o(writeaddr_o), .writedata_o(writedata_o),
      .rsaddr_i(rsaddr_i), .rtaddr_i(rtaddr_i),
      .rs_hit_o(rs_hit_o), .rs_data_o(rs_data_o),
      .rt_hit_o(rt_hit_o), .rt_data_o(rt_data_o),
      .count_o(count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: pending writes as a plain ordered list, oldest first.
   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;
   ent_t mq[$];

   function automatic void lookup(input logic [ADDR_W-1:0] a, output logic hit, output logic [DATA_W-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (a != '0) begin
         foreach (mq[i]) begin
            if (mq[i].a == a) begin
               hit = 1'b1;
               d   = mq[i].d;
            end
         end
      end
   endfunction

   logic              m_ready, m_wr, m_rs_hit, m_rt_hit;
   logic [ADDR_W-1:0] m_waddr;
   logic [DATA_W-1:0] m_wdata, m_rs_data, m_rt_data;
   ent_t              m_new;

   // Inputs change only just after posedge, so at negedge they are the values the next edge sees.
   always @(negedge clk) begin
      m_ready = (mq.size() < DEPTH);
      m_wr    = (mq.size() != 0) && wr_grant_i;
      m_waddr = (mq.size() != 0) ? mq[0].a : '0;
      m_wdata = (mq.size() != 0) ? mq[0].d : '0;
      lookup(rsaddr_i, m_rs_hit, m_rs_data);
      lookup(rtaddr_i, m_rt_hit, m_rt_data);
      if (chk_en) begin
         check("model_count", 32'(count_o), 32'(mq.size()));
         check("model_ready", 32'(wb_ready_o), 32'(m_ready));
         check("model_regwrite", 32'(regwrite_o), 32'(m_wr));
         check("model_writeaddr", 32'(writeaddr_o), 32'(m_waddr));
         check("model_writedata", writedata_o, m_wdata);
         check("model_rs_hit", 32'(rs_hit_o), 32'(m_rs_hit));
         check("model_rs_data", rs_data_o, m_rs_data);
         check("model_rt_hit", 32'(rt_hit_o), 32'(m_rt_hit));
         check("model_rt_data", rt_data_o, m_rt_data);
      end
      if (rst_i) begin
         mq.delete();
      end else begin
         if (m_wr) begin
            $display("retire r%0d <= %08h", mq[0].a, mq[0].d);
            void'(mq.pop_front());
         end
         if (wb_valid_i && m_ready) begin
            $display("accept r%0d <= %08h%s", wb_addr_i, wb_data_i, (wb_addr_i == 0) ? " (dropped)" : "");
            if (wb_addr_i != '0) begin
               m_new.a = wb_addr_i;
               m_new.d = wb_data_i;
               mq.push_back(m_new);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   int  nxt;
   logic acc;
   int  waited;

   initial begin
      // Reset then idle
      step();
      step();
      rst_i  = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_count", 32'(count_o), 0);
      check("rst_ready", 32'(wb_ready_o), 1);
      check("rst_regwrite", 32'(regwrite_o), 0);
      check("rst_rs_hit", 32'(rs_hit_o), 0);
      check("rst_writedata", writedata_o, 0);

      // Single push, granted port: visible next cycle, retired the cycle after
      step();
      wr_grant_i = 1'b1;
      wb_valid_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
      step();
      wb_valid_i = 1'b0;
      @(negedge clk);
      check("single_regwrite", 32'(regwrite_o), 1);
      check("single_addr", 32'(writeaddr_o), 5);
      check("single_data", writedata_o, 32'hDEADBEEF);
      step();
      @(negedge clk);
      check("single_count_after", 32'(count_o), 0);

      // Fill with grant low, forwarding, ignored fifth push, ordered drain
      step();
      wr_grant_i = 1'b0;
      wb_valid_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'd1; step();
      wb_addr_i = 5'd3; wb_data_i = 32'd2; step();
      wb_addr_i = 5'd7; wb_data_i = 32'd9; step();
      wb_addr_i = 5'd1; wb_data_i = 32'd4; step();
      wb_addr_i = 5'd9; wb_data_i = 32'h55;
      rsaddr_i = 5'd3; rtaddr_i = 5'd7;
      @(negedge clk);
      check("full_count", 32'(count_o), 4);
      check("full_ready", 32'(wb_ready_o), 0);
      check("fwd_rs_hit", 32'(rs_hit_o), 1);
      check("fwd_rs_data", rs_data_o, 2);
      check("fwd_rt_data", rt_data_o, 9);
      step();
      @(negedge clk);
      check("fifth_ignored_count", 32'(count_o), 4);
      step();
      wb_valid_i = 1'b0; wr_grant_i = 1'b1;
      @(negedge clk);
      check("drain0_addr", 32'(writeaddr_o), 3);
      check("drain0_data", writedata_o, 1);
      step();
      @(negedge clk);
      check("drain1_addr", 32'(writeaddr_o), 3);
      check("drain1_data", writedata_o, 2);
      check("drain1_rs_data", rs_data_o, 2);
      step();
      @(negedge clk);
      check("drain2_addr", 32'(writeaddr_o), 7);
      check("drain2_data", writedata_o, 9);
      step();
      @(negedge clk);
      check("drain3_addr", 32'(writeaddr_o), 1);
      check("drain3_data", writedata_o, 4);
      check("drain3_regwrite", 32'(regwrite_o), 1);
      step();
      @(negedge clk);
      check("drain_done_count", 32'(count_o), 0);
      check("drain_done_regwrite", 32'(regwrite_o), 0);

      // Write to r0 is accepted and dropped
      step();
      wr_grant_i = 1'b0;
      wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'h1234;
      rsaddr_i = 5'd0;
      @(negedge clk);
      check("r0_ready", 32'(wb_ready_o), 1);
      step();
      wb_valid_i = 1'b0; wr_grant_i = 1'b1;
      @(negedge clk);
      check("r0_count", 32'(count_o), 0);
      check("r0_regwrite", 32'(regwrite_o), 0);
      check("r0_rs_hit", 32'(rs_hit_o), 0);

      // Full queue streaming with grant and held request; pointers wrap
      step();
      wr_grant_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wb_valid_i = 1'b1; wb_addr_i = ADDR_W'(10 + i); wb_data_i = 32'(100 + i);
         step();
      end
      nxt = 0;
      wb_addr_i = 5'd20; wb_data_i = 32'd200;
      wr_grant_i = 1'b1;
      rsaddr_i = 5'd20; rtaddr_i = 5'd13;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         acc = wb_ready_o;
         check("stream_count_range", 32'((count_o >= 3) && (count_o <= 4)), 1);
         step();
         if (acc) begin
            nxt++;
            wb_addr_i = ADDR_W'(20 + (nxt % 8));
            wb_data_i = 32'(200 + nxt);
         end
      end
      wb_valid_i = 1'b0;
      waited = 0;
      while (waited < 20) begin
         @(negedge clk);
         if (count_o == 0) break;
         step();
         waited++;
      end
      check("stream_drained", 32'(count_o), 0);

      // Reset in the middle of a drain discards the rest
      step();
      wr_grant_i = 1'b0;
      wb_valid_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = 32'hA; step();
      wb_addr_i = 5'd4; wb_data_i = 32'hB; step();
      wb_addr_i = 5'd6; wb_data_i = 32'hC; step();
      wb_valid_i = 1'b0; wr_grant_i = 1'b1;
      @(negedge clk);
      check("midrst_pre_regwrite", 32'(regwrite_o), 1);
      check("midrst_pre_addr", 32'(writeaddr_o), 2);
      step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      @(negedge clk);
      check("midrst_count", 32'(count_o), 0);
      check("midrst_regwrite", 32'(regwrite_o), 0);
      for (int c = 0; c < 3; c++) begin
         step();
         @(negedge clk);
         check("midrst_no_write", 32'(regwrite_o), 0);
      end

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
